// File: rtl/led_controller_pkg.sv
// Shared types and constants for the OLED power/init sequencer.
// Holds the FSM state encoding, the init command ROM and default timings.
package led_controller_pkg;

  typedef enum logic [3:0] {
    OFF, PWR_WAIT, RST_LOW, RST_WAIT, INIT, VCC_WAIT,
    DISP_ON, ON_WAIT, ON, SHUTDOWN, OFF_WAIT
  } state_t;

  localparam int T_PWR_DEF   = 2_000_000;
  localparam int T_RST_DEF   = 300;
  localparam int T_VCC_DEF   = 2_500_000;
  localparam int T_ON_DEF    = 10_000_000;
  localparam int T_OFF_DEF   = 40_000_000;
  localparam int SPI_DIV_DEF = 8;

  localparam logic [7:0] OP_DISP_ON  = 8'hAF;
  localparam logic [7:0] OP_DISP_OFF = 8'hAE;

  localparam int INIT_LEN = 44;
  localparam logic [INIT_LEN*8-1:0] INIT_ROM = {
    8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
    8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0,
    8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E,
    8'h87, 8'h06, 8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E, 8'h25,
    8'h00, 8'h00, 8'h5F, 8'h3F
  };

  // Entry 0 sits in the most significant byte so the list reads in send order.
  function automatic logic [7:0] init_byte(input logic [5:0] idx);
    return INIT_ROM[8*(INIT_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/led_spi_tx.sv
// Mode-3 SPI byte transmitter, MSB first, with chip select framing.
// Latency: CS falls 1 cycle after start; done pulses 20*SPI_DIV cycles after CS falls.
// Backpressure: start is accepted only while busy is low.
module led_spi_tx
  import led_controller_pkg::*;
#(
  parameter int SPI_DIV = SPI_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_dat,
  input  logic       tx_dc,
  output logic       busy,
  output logic       done,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       spi_cs,
  output logic       data_command
);

  logic [7:0] div_cnt;
  logic [7:0] byte_q;
  logic [4:0] half_cnt;
  logic [4:0] half_nxt;
  logic [2:0] bit_idx;

  assign half_nxt = half_cnt + 5'd1;
  // Odd half-period 2i+1 carries bit 7-i.
  assign bit_idx  = 3'd7 - half_nxt[3:1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      spi_clk      <= 1'b1;
      spi_mosi     <= 1'b0;
      spi_cs       <= 1'b1;
      data_command <= 1'b0;
      div_cnt      <= 8'd0;
      half_cnt     <= 5'd0;
      byte_q       <= 8'd0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy         <= 1'b1;
          spi_cs       <= 1'b0;
          spi_mosi     <= tx_dat[7];
          data_command <= tx_dc;
          byte_q       <= tx_dat;
          div_cnt      <= 8'd0;
          half_cnt     <= 5'd0;
        end
      end else if (div_cnt == 8'(SPI_DIV - 1)) begin
        div_cnt  <= 8'd0;
        half_cnt <= half_nxt;
        if (half_nxt == 5'd20) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else if (half_nxt == 5'd17) begin
          spi_cs <= 1'b1;
        end else if (half_nxt <= 5'd16) begin
          spi_clk <= ~half_nxt[0];
          if (half_nxt[0]) spi_mosi <= byte_q[bit_idx];
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/led_controller.sv
// OLED panel power-up / init / shutdown sequencer driving an SPI byte transmitter.
// Latency: supply enables and RESET change 1 cycle after the deciding state edge.
// Backpressure: power_on is a level only looked at in OFF and ON.
module led_controller
  import led_controller_pkg::*;
#(
  parameter int T_PWR   = T_PWR_DEF,
  parameter int T_RST   = T_RST_DEF,
  parameter int T_VCC   = T_VCC_DEF,
  parameter int T_ON    = T_ON_DEF,
  parameter int T_OFF   = T_OFF_DEF,
  parameter int SPI_DIV = SPI_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic power_on,
  output logic SPI_CLK,
  output logic SPI_MOSI,
  output logic SPI_CS,
  output logic data_command,
  output logic VCCen,
  output logic PMODen,
  output logic RESET
);

  state_t      state_q, state_nxt;
  logic [31:0] timer_q;
  logic [5:0]  idx_q, idx_nxt;
  logic        pmod_q, pmod_nxt;
  logic        vcc_q, vcc_nxt;
  logic        rst_q, rst_nxt;
  logic        inflight_q, inflight_nxt;
  logic        tx_start, tx_busy, tx_done;
  logic [7:0]  tx_dat;

  function automatic logic hit(input int n);
    return timer_q == 32'(n - 1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= OFF;
      timer_q    <= 32'd0;
      idx_q      <= 6'd0;
      pmod_q     <= 1'b0;
      vcc_q      <= 1'b0;
      rst_q      <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      timer_q    <= (state_nxt != state_q) ? 32'd0 : timer_q + 32'd1;
      idx_q      <= idx_nxt;
      pmod_q     <= pmod_nxt;
      vcc_q      <= vcc_nxt;
      rst_q      <= rst_nxt;
      inflight_q <= inflight_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    idx_nxt      = idx_q;
    pmod_nxt     = pmod_q;
    vcc_nxt      = vcc_q;
    rst_nxt      = rst_q;
    inflight_nxt = inflight_q;
    tx_start     = 1'b0;
    tx_dat       = init_byte(idx_q);

    // One byte in flight at a time: launch when idle, retire on done.
    if (state_q inside {INIT, DISP_ON, SHUTDOWN}) begin
      tx_start = !tx_busy && !inflight_q;
      if (tx_start) inflight_nxt = 1'b1;
      if (tx_done)  inflight_nxt = 1'b0;
    end

    case (state_q)
      OFF: if (power_on) begin
        pmod_nxt  = 1'b1;
        state_nxt = PWR_WAIT;
      end
      PWR_WAIT: if (hit(T_PWR)) begin
        rst_nxt   = 1'b0;
        state_nxt = RST_LOW;
      end
      RST_LOW: if (hit(T_RST)) begin
        rst_nxt   = 1'b1;
        state_nxt = RST_WAIT;
      end
      RST_WAIT: if (hit(T_RST)) begin
        idx_nxt   = 6'd0;
        state_nxt = INIT;
      end
      INIT: if (tx_done) begin
        if (idx_q == 6'(INIT_LEN - 1)) begin
          vcc_nxt   = 1'b1;
          state_nxt = VCC_WAIT;
        end else begin
          idx_nxt = idx_q + 6'd1;
        end
      end
      VCC_WAIT: if (hit(T_VCC)) state_nxt = DISP_ON;
      DISP_ON: begin
        tx_dat = OP_DISP_ON;
        if (tx_done) state_nxt = ON_WAIT;
      end
      ON_WAIT: if (hit(T_ON)) state_nxt = ON;
      ON: if (!power_on) state_nxt = SHUTDOWN;
      SHUTDOWN: begin
        tx_dat = OP_DISP_OFF;
        if (tx_done) begin
          vcc_nxt   = 1'b0;
          state_nxt = OFF_WAIT;
        end
      end
      OFF_WAIT: if (hit(T_OFF)) begin
        pmod_nxt  = 1'b0;
        state_nxt = OFF;
      end
      default: state_nxt = OFF;
    endcase
  end

  led_spi_tx #(.SPI_DIV(SPI_DIV)) u_spi_tx (
    .clk          (clk),
    .reset        (reset),
    .start        (tx_start),
    .tx_dat       (tx_dat),
    .tx_dc        (1'b0),
    .busy         (tx_busy),
    .done         (tx_done),
    .spi_clk      (SPI_CLK),
    .spi_mosi     (SPI_MOSI),
    .spi_cs       (SPI_CS),
    .data_command (data_command)
  );

  assign VCCen  = vcc_q;
  assign PMODen = pmod_q;
  assign RESET  = rst_q;

endmodule

// File: tb/tb_led_controller.sv
// Directed-plus-random bench: a pin-level monitor rebuilds SPI bytes and edge times,
// which are compared against the sequence and timings derived from the datasheet rules.
module tb_led_controller;

  localparam int T_PWR = 100, T_RST = 10, T_VCC = 200, T_ON = 300, T_OFF = 400, DIV = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic power_on = 1'b0;
  logic SPI_CLK, SPI_MOSI, SPI_CS, data_command, VCCen, PMODen, RESET;

  led_controller #(
    .T_PWR(T_PWR), .T_RST(T_RST), .T_VCC(T_VCC), .T_ON(T_ON), .T_OFF(T_OFF), .SPI_DIV(DIV)
  ) dut (
    .clk(clk), .reset(reset), .power_on(power_on),
    .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS), .data_command(data_command),
    .VCCen(VCCen), .PMODen(PMODen), .RESET(RESET)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  byte unsigned exp_rom [44] = '{
    8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
    8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0,
    8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E,
    8'h87, 8'h06, 8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E, 8'h25,
    8'h00, 8'h00, 8'h5F, 8'h3F
  };

  int checks = 0;
  int errors = 0;

  // Monitor state: captured bytes and the cycles at which pins changed.
  logic [7:0] bq [$];
  logic       dcq [$];
  int         cs_fall_q [$];
  int         cs_rise_q [$];
  int pmod_rise_c = 0, pmod_fall_c = 0, rst_fall_c = 0, rst_rise_c = 0;
  int vcc_rise_c = 0, vcc_fall_c = 0;
  int pmod_rise_n = 0, pmod_fall_n = 0, vcc_fall_n = 0;
  int tim_err = 0;

  initial begin
    logic p_clk, p_cs, p_mosi, p_dc, p_vcc, p_pmod, p_rst, p_reset;
    logic in_byte, have_t0, dc_at;
    logic [7:0] sh;
    int t0, nf, nr, nbits;
    p_clk = 1; p_cs = 1; p_mosi = 0; p_dc = 0; p_vcc = 0; p_pmod = 0; p_rst = 1; p_reset = 0;
    in_byte = 0; have_t0 = 0; dc_at = 0; sh = 0; t0 = 0; nf = 0; nr = 0; nbits = 0;
    forever begin
      @(negedge clk);
      if (reset && p_reset) begin
        if (p_cs && !SPI_CS) begin
          if (have_t0 && (cyc - t0) < 20*DIV) tim_err++;
          in_byte = 1; have_t0 = 1; t0 = cyc; nf = 0; nr = 0; nbits = 0; dc_at = data_command;
          cs_fall_q.push_back(cyc);
        end
        if (in_byte && !SPI_CS && p_clk && !SPI_CLK) begin
          if ((cyc - t0) != (2*nf + 1)*DIV) tim_err++;
          nf++;
        end
        if (in_byte && !SPI_CS && !p_clk && SPI_CLK) begin
          if ((cyc - t0) != (2*nr + 2)*DIV) tim_err++;
          nr++; nbits++;
          sh = {sh[6:0], SPI_MOSI};
        end
        if (in_byte && !p_cs && SPI_CS) begin
          if ((cyc - t0) != 17*DIV || nbits != 8) tim_err++;
          bq.push_back(sh); dcq.push_back(dc_at); cs_rise_q.push_back(cyc);
          in_byte = 0;
        end
        if (SPI_MOSI !== p_mosi && !(p_cs && !SPI_CS) && !(p_clk && !SPI_CLK)) tim_err++;
        if (data_command !== p_dc && !(p_cs && !SPI_CS)) tim_err++;
        if (SPI_CS && !SPI_CLK) tim_err++;
        if (!p_pmod && PMODen) begin pmod_rise_c = cyc; pmod_rise_n++; end
        if (p_pmod && !PMODen) begin pmod_fall_c = cyc; pmod_fall_n++; end
        if (p_rst && !RESET) rst_fall_c = cyc;
        if (!p_rst && RESET) rst_rise_c = cyc;
        if (!p_vcc && VCCen) vcc_rise_c = cyc;
        if (p_vcc && !VCCen) begin vcc_fall_c = cyc; vcc_fall_n++; end
      end else begin
        in_byte = 0; have_t0 = 0;
      end
      p_clk = SPI_CLK; p_cs = SPI_CS; p_mosi = SPI_MOSI; p_dc = data_command;
      p_vcc = VCCen; p_pmod = PMODen; p_rst = RESET; p_reset = reset;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && bq.size() < n; k++) @(posedge clk);
    chk(tag, 32'(bq.size() >= n), 32'd1);
  endtask

  task automatic check_powerup(input int base);
    for (int i = 0; i < 45; i++) begin
      chk($sformatf("byte%0d", base + i), 32'(bq[base + i]),
          (i < 44) ? 32'(exp_rom[i]) : 32'h0000_00AF);
      chk($sformatf("dc%0d", base + i), 32'(dcq[base + i]), 32'd0);
    end
  endtask

  initial begin
    int t_req, gap, k;

    // Reset with power_on low.
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_spi_clk", 32'(SPI_CLK), 32'd1);
    chk("rst_spi_cs", 32'(SPI_CS), 32'd1);
    chk("rst_mosi", 32'(SPI_MOSI), 32'd0);
    chk("rst_dc", 32'(data_command), 32'd0);
    chk("rst_vccen", 32'(VCCen), 32'd0);
    chk("rst_pmoden", 32'(PMODen), 32'd0);
    chk("rst_reset_pin", 32'(RESET), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("off_idle_pmoden", 32'(PMODen), 32'd0);
    chk("off_idle_bytes", 32'(bq.size()), 32'd0);

    // Power-up sequence timing.
    @(posedge clk); #1 power_on = 1'b1; t_req = cyc;
    wait_bytes(1, 600, "first_byte_seen");
    chk("pmod_next_cycle", 32'(pmod_rise_c), 32'(t_req + 1));
    chk("reset_fall_delay", 32'(rst_fall_c - pmod_rise_c), 32'(T_PWR));
    chk("reset_low_width", 32'(rst_rise_c - rst_fall_c), 32'(T_RST));
    gap = cs_fall_q[0] - rst_rise_c;
    chk("init_after_rst_wait", 32'(gap >= T_RST && gap <= T_RST + 2), 32'd1);
    chk("first_byte_fd", 32'(bq[0]), 32'h0000_00FD);

    wait_bytes(45, 4000, "powerup_45_bytes");
    check_powerup(0);
    chk("vcc_after_last_init", 32'(vcc_rise_c > cs_rise_q[43] && vcc_rise_c < cs_fall_q[44]), 32'd1);
    gap = cs_fall_q[44] - vcc_rise_c;
    chk("vcc_wait_len", 32'(gap >= T_VCC && gap <= T_VCC + 2), 32'd1);
    repeat (T_ON + 60) @(posedge clk);
    chk("on_no_extra_bytes", 32'(bq.size()), 32'd45);
    chk("on_vccen", 32'(VCCen), 32'd1);

    // One-cycle drop in ON: shutdown; level high again is a re-request during OFF_WAIT.
    @(posedge clk); #1 power_on = 1'b0;
    @(posedge clk); #1 power_on = 1'b1;
    wait_bytes(46, 200, "shutdown_byte_seen");
    chk("shutdown_ae", 32'(bq[45]), 32'h0000_00AE);
    for (int j = 0; j < 200 && vcc_fall_n == 0; j++) @(posedge clk);
    chk("vcc_fall_seen", 32'(vcc_fall_n), 32'd1);
    chk("vcc_fall_after_ae", 32'(vcc_fall_c > cs_rise_q[45]), 32'd1);
    for (int j = 0; j < 600 && pmod_fall_n == 0; j++) @(posedge clk);
    chk("pmod_fall_seen", 32'(pmod_fall_n), 32'd1);
    chk("off_wait_len", 32'(pmod_fall_c - vcc_fall_c), 32'(T_OFF));
    for (int j = 0; j < 20 && pmod_rise_n < 2; j++) @(posedge clk);
    chk("repower_rise_count", 32'(pmod_rise_n), 32'd2);
    chk("repower_after_fall", 32'(pmod_rise_c), 32'(pmod_fall_c + 1));

    // Random glitch on power_on in the middle of INIT must be ignored.
    k = int'($urandom_range(2, 40));
    wait_bytes(46 + k, 3000, "glitch_point_reached");
    @(posedge clk); #1 power_on = 1'b0;
    repeat (int'($urandom_range(1, 4))) @(posedge clk);
    #1 power_on = 1'b1;
    wait_bytes(91, 4000, "second_powerup_bytes");
    check_powerup(46);
    repeat (T_ON + 60) @(posedge clk);
    chk("glitch_no_shutdown", 32'(bq.size()), 32'd91);
    chk("glitch_on_vccen", 32'(VCCen), 32'd1);
    chk("glitch_on_pmoden", 32'(PMODen), 32'd1);

    // Reset in the middle of the shutdown byte.
    @(posedge clk); #1 power_on = 1'b0;
    for (int j = 0; j < 100 && cs_fall_q.size() < 92; j++) @(posedge clk);
    chk("shutdown_cs_fall_seen", 32'(cs_fall_q.size()), 32'd92);
    repeat (int'($urandom_range(0, 28))) @(posedge clk);
    #1;
    chk("mid_byte_cs_low", 32'(SPI_CS), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cs", 32'(SPI_CS), 32'd1);
    chk("abort_spi_clk", 32'(SPI_CLK), 32'd1);
    chk("abort_vccen", 32'(VCCen), 32'd0);
    chk("abort_pmoden", 32'(PMODen), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("abort_not_resumed", 32'(bq.size()), 32'd91);
    chk("after_abort_cs_idle", 32'(SPI_CS), 32'd1);
    chk("after_abort_pmoden", 32'(PMODen), 32'd0);
    chk("after_abort_reset_pin", 32'(RESET), 32'd1);

    chk("spi_pin_timing", 32'(tim_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_controller.md
LED_CONTROLLER -- requirements
Module: led_controller

Interface
REQ-001 Parameter T_PWR, default 2_000_000, clk cycles to wait after PMODen rises (20 ms at 100 MHz).
REQ-002 Parameter T_RST, default 300, clk cycles for the RESET low pulse and for the wait after RESET release (3 us).
REQ-003 Parameter T_VCC, default 2_500_000, clk cycles to wait after VCCen rises (25 ms).
REQ-004 Parameter T_ON, default 10_000_000, clk cycles to wait after the display-on command (100 ms).
REQ-005 Parameter T_OFF, default 40_000_000, clk cycles to wait after VCCen falls (400 ms).
REQ-006 Parameter SPI_DIV, default 8, clk cycles per SPI_CLK half-period (6.25 MHz at 100 MHz).
REQ-007 Port clk, input, 1, sole clock, 100 MHz nominal, rising edge.
REQ-008 Port reset, input, 1, synchronous active-low reset.
REQ-009 Port power_on, input, 1, level request: 1 = display on, 0 = display off.
REQ-010 Port SPI_CLK, output, 1, SPI mode-3 serial clock, idle high.
REQ-011 Port SPI_MOSI, output, 1, serial data, MSB first.
REQ-012 Port SPI_CS, output, 1, active-low chip select.
REQ-013 Port data_command, output, 1, 0 = command byte, 1 = data byte.
REQ-014 Port VCCen, output, 1, panel high-voltage enable.
REQ-015 Port PMODen, output, 1, logic-supply enable.
REQ-016 Port RESET, output, 1, active-low display reset.

Function
REQ-017 The FSM SHALL use the states OFF, PWR_WAIT, RST_LOW, RST_WAIT, INIT, VCC_WAIT, DISP_ON, ON_WAIT, ON, SHUTDOWN, OFF_WAIT.
REQ-018 OFF: if power_on=1, set PMODen=1 and go to PWR_WAIT.
REQ-019 PWR_WAIT holds for T_PWR cycles, then RESET=0 and RST_LOW.
REQ-020 RST_LOW holds for T_RST cycles, then RESET=1 and RST_WAIT.
REQ-021 RST_WAIT holds for T_RST cycles, then INIT.
REQ-022 INIT sends the 44-byte command ROM in order, all with data_command=0: FD 12 AE A0 72 A1 00 A2 00 A4 A8 3F AD 8E B0 0B B1 31 B3 F0 8A 64 8B 78 8C 64 BB 3A BE 3E 87 06 81 91 82 50 83 7D 2E 25 00 00 5F 3F.
REQ-023 After the last INIT byte, set VCCen=1 and go to VCC_WAIT for T_VCC cycles, then DISP_ON.
REQ-024 DISP_ON sends command 0xAF, then ON_WAIT holds for T_ON cycles, then ON.
REQ-025 ON: if power_on=0, go to SHUTDOWN, which sends command 0xAE, then sets VCCen=0 and enters OFF_WAIT.
REQ-026 OFF_WAIT holds for T_OFF cycles, then sets PMODen=0 and returns to OFF.
REQ-027 power_on SHALL be sampled only in OFF and ON; toggles in other states are ignored, and the running sequence completes. A re-request during OFF_WAIT restarts power-up from OFF.
REQ-028 SPI byte timing, with t0 = the cycle SPI_CS falls:
- At t0, data_command and SPI_MOSI=bit7 are valid.
- SPI_CLK falls at t0+(2i+1)*SPI_DIV and rises at t0+(2i+2)*SPI_DIV, for i=0..7.
- SPI_MOSI changes only on falling edges, to bit 7-i.
- SPI_CS rises at t0+17*SPI_DIV.
- The next byte starts no earlier than t0+20*SPI_DIV.
REQ-029 Outside a byte transfer, SPI_CLK=1 and SPI_CS=1; SPI_MOSI and data_command hold their last values.

Reset
REQ-030 When reset=0 at a rising clk edge, the block SHALL enter OFF with these values:
- SPI_CLK=1, SPI_CS=1, SPI_MOSI=0, data_command=0.
- VCCen=0, PMODen=0, RESET=1.
- All counters and the ROM index cleared.
REQ-031 Reset SHALL take priority over every state, including mid-byte. An aborted byte is not resumed.

Structure
REQ-032 Package led_controller_pkg SHALL hold the state enum, the 44-entry init ROM, the opcodes 0xAF and 0xAE, and the default timing constants.
REQ-033 Sub-module led_spi_tx (byte in, dc in, start/busy/done handshake, SPI pin drivers) SHALL implement REQ-028. The FSM SHALL pulse start only when busy=0.

Verification
The benches override parameters to T_PWR=100, T_RST=10, T_VCC=200, T_ON=300, T_OFF=400, SPI_DIV=2.
REQ-034 Reset low 10 cycles with power_on=0 -> all outputs at reset values; state stays OFF.
REQ-035 power_on 0->1 -> checks in order:
- PMODen=1 next cycle.
- RESET low for exactly 10 cycles, starting 100 cycles later.
- After a further 10 cycles, the first byte 0xFD with data_command=0.
REQ-036 Capture all SPI bytes of power-up -> the 44 ROM bytes then 0xAF, each 8 bits MSB-first on SPI_CLK rising edges. VCCen rises after the 44th byte's SPI_CS rise and before 0xAF.
REQ-037 In ON, drop power_on for 1 cycle -> 0xAE sent, then VCCen=0, then PMODen=0 after 400 cycles. Reassert during OFF_WAIT -> new power-up starts only after PMODen has fallen.
REQ-038 Pulse power_on low during INIT -> INIT, VCC_WAIT, DISP_ON and ON_WAIT complete unchanged, ending in ON.
REQ-039 Assert reset mid-byte -> next cycle SPI_CS=1, SPI_CLK=1, VCCen=0, PMODen=0.
